// File: rtl/logic_101.sv
// Serial "101" pattern detector: Moore FSM with registered detect flag and a
// saturating count of detections since reset.
module logic_101 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iIN,
  output logic             oOUT,
  output logic [CNT_W-1:0] oCOUNT,
  output logic [1:0]       oSTATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           next_state;
  logic             out_reg;
  logic [CNT_W-1:0] count_reg;

  // State register; reset wins over any transition on the same edge.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the S101 exit depends on whether the trailing 1 may
  // begin the next match. Any unexpected encoding falls back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = iIN ? S1   : IDLE;
      S1:      next_state = iIN ? S1   : S10;
      S10:     next_state = iIN ? S101 : IDLE;
      S101: begin
        if (OVERLAP != 0) begin
          next_state = iIN ? S1 : S10;
        end else begin
          next_state = iIN ? S1 : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Detect flag and saturating counter, both updated when entering S101 so
  // the flag is a pure function of the registered state.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      out_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      out_reg <= (next_state == S101);
      if ((next_state == S101) && (count_reg != CNT_MAX)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign oOUT   = out_reg;
  assign oCOUNT = count_reg;
  assign oSTATE = state;

endmodule

// File: tb/tb_logic_101.sv
// Scoreboard bench for logic_101: three instances (overlapping, non-overlapping,
// 2-bit non-overlapping counter) share one bitstream; a history-based model
// pushes expectations per bit and each test pops and compares them.
module tb_logic_101;

  logic       clk;
  logic       rst;
  logic       in_bit;

  logic       ov_out;
  logic [7:0] ov_cnt;
  logic [1:0] ov_st;
  logic       no_out;
  logic [7:0] no_cnt;
  logic [1:0] no_st;
  logic       c2_out;
  logic [1:0] c2_cnt;
  logic [1:0] c2_st;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0] hist;
    int         len;
    int         cnt;
  } mdl_t;

  typedef struct {
    logic [1:0] ov_st;
    logic       ov_out;
    logic [7:0] ov_cnt;
    logic [1:0] no_st;
    logic       no_out;
    logic [7:0] no_cnt;
    logic [1:0] c2_st;
    logic       c2_out;
    logic [1:0] c2_cnt;
  } exp_t;

  mdl_t m_ov;
  mdl_t m_no;
  mdl_t m_c2;
  exp_t exp_q[$];

  logic_101 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .iCLK(clk), .iRST(rst), .iIN(in_bit),
    .oOUT(ov_out), .oCOUNT(ov_cnt), .oSTATE(ov_st)
  );

  logic_101 #(.OVERLAP(0), .CNT_W(8)) dut_no (
    .iCLK(clk), .iRST(rst), .iIN(in_bit),
    .oOUT(no_out), .oCOUNT(no_cnt), .oSTATE(no_st)
  );

  logic_101 #(.OVERLAP(0), .CNT_W(2)) dut_c2 (
    .iCLK(clk), .iRST(rst), .iIN(in_bit),
    .oOUT(c2_out), .oCOUNT(c2_cnt), .oSTATE(c2_st)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Model: state is the longest suffix of the bits seen since the last
  // restart that is a prefix of 101; a full 101 is a detection.
  function automatic void mdl_step(inout mdl_t m, input bit b, input bit r,
                                   input bit overlap, input int cmax,
                                   output int st, output bit o);
    if (r) begin
      m.hist = 3'b000;
      m.len  = 0;
      m.cnt  = 0;
      st     = 0;
      o      = 1'b0;
      return;
    end
    m.hist = {m.hist[1:0], b};
    if (m.len < 3) m.len++;
    if (m.len >= 3 && m.hist == 3'b101)           st = 3;
    else if (m.len >= 2 && m.hist[1:0] == 2'b10)  st = 2;
    else if (m.hist[0])                           st = 1;
    else                                          st = 0;
    o = (st == 3);
    if (o) begin
      if (m.cnt < cmax) m.cnt++;
      if (!overlap) m.len = 0;
    end
  endfunction

  // Drive one bit (and reset), push expectations, advance one edge
  task automatic apply_bit(input bit b, input bit r);
    exp_t e;
    int   st;
    bit   o;
    in_bit = b;
    rst    = r;
    mdl_step(m_ov, b, r, 1'b1, 255, st, o);
    e.ov_st = 2'(st); e.ov_out = o; e.ov_cnt = 8'(m_ov.cnt);
    mdl_step(m_no, b, r, 1'b0, 255, st, o);
    e.no_st = 2'(st); e.no_out = o; e.no_cnt = 8'(m_no.cnt);
    mdl_step(m_c2, b, r, 1'b0, 3, st, o);
    e.c2_st = 2'(st); e.c2_out = o; e.c2_cnt = 2'(m_c2.cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply_bit(1'b1, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (ov_st !== e.ov_st || ov_out !== e.ov_out || ov_cnt !== e.ov_cnt) begin
      n_errors++;
      $display("FAIL reset_ov: got st=%0d out=%0d cnt=%0d expected st=%0d out=%0d cnt=%0d",
               ov_st, ov_out, ov_cnt, e.ov_st, e.ov_out, e.ov_cnt);
    end
    n_checks++;
    if (no_st !== e.no_st || no_out !== e.no_out || no_cnt !== e.no_cnt ||
        c2_st !== e.c2_st || c2_out !== e.c2_out || c2_cnt !== e.c2_cnt) begin
      n_errors++;
      $display("FAIL reset_no_c2: got %0d/%0d/%0d %0d/%0d/%0d expected 0/0/0 0/0/0",
               no_st, no_out, no_cnt, c2_st, c2_out, c2_cnt);
    end
  endtask

  task automatic test_basic();
    bit   seq[] = '{0, 0, 1, 0, 1, 0};
    exp_t e;
    int   pulses = 0;
    apply_bit(1'b0, 1'b1);
    e = exp_q.pop_front();
    foreach (seq[i]) begin
      apply_bit(seq[i], 1'b0);
      e = exp_q.pop_front();
      if (ov_out === 1'b1) pulses++;
      n_checks++;
      if (ov_out !== e.ov_out || ov_st !== e.ov_st || ov_cnt !== e.ov_cnt) begin
        n_errors++;
        $display("FAIL basic step %0d: got st=%0d out=%0d cnt=%0d expected st=%0d out=%0d cnt=%0d",
                 i, ov_st, ov_out, ov_cnt, e.ov_st, e.ov_out, e.ov_cnt);
      end
    end
    n_checks++;
    if (pulses != 1 || ov_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL basic_summary: got pulses=%0d cnt=%0d expected pulses=1 cnt=1", pulses, ov_cnt);
    end
  endtask

  task automatic test_overlap();
    bit   seq[] = '{1, 0, 1, 0, 1};
    exp_t e;
    int   ov_p = 0;
    int   no_p = 0;
    apply_bit(1'b0, 1'b1);
    e = exp_q.pop_front();
    foreach (seq[i]) begin
      apply_bit(seq[i], 1'b0);
      e = exp_q.pop_front();
      if (ov_out === 1'b1) ov_p++;
      if (no_out === 1'b1) no_p++;
      n_checks++;
      if (ov_out !== e.ov_out || ov_cnt !== e.ov_cnt || ov_st !== e.ov_st) begin
        n_errors++;
        $display("FAIL overlap step %0d: got out=%0d cnt=%0d st=%0d expected out=%0d cnt=%0d st=%0d",
                 i, ov_out, ov_cnt, ov_st, e.ov_out, e.ov_cnt, e.ov_st);
      end
      n_checks++;
      if (no_out !== e.no_out || no_cnt !== e.no_cnt || no_st !== e.no_st) begin
        n_errors++;
        $display("FAIL no_overlap step %0d: got out=%0d cnt=%0d st=%0d expected out=%0d cnt=%0d st=%0d",
                 i, no_out, no_cnt, no_st, e.no_out, e.no_cnt, e.no_st);
      end
    end
    n_checks++;
    if (ov_p != 2 || ov_cnt !== 8'd2 || no_p != 1 || no_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL overlap_summary: got ov=%0d/%0d no=%0d/%0d expected ov=2/2 no=1/1",
               ov_p, ov_cnt, no_p, no_cnt);
    end
  endtask

  task automatic test_no_match();
    bit   seq[] = '{1, 1, 0, 0, 1, 1, 1};
    exp_t e;
    apply_bit(1'b1, 1'b1);
    e = exp_q.pop_front();
    foreach (seq[i]) begin
      apply_bit(seq[i], 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (ov_out !== e.ov_out || ov_st !== e.ov_st || no_out !== e.no_out) begin
        n_errors++;
        $display("FAIL no_match step %0d: got out=%0d st=%0d expected out=%0d st=%0d",
                 i, ov_out, ov_st, e.ov_out, e.ov_st);
      end
    end
    n_checks++;
    if (ov_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL no_match_count: got %0d expected 0", ov_cnt);
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    int   pulses = 0;
    apply_bit(1'b0, 1'b1);
    e = exp_q.pop_front();
    apply_bit(1'b1, 1'b0);
    e = exp_q.pop_front();
    apply_bit(1'b0, 1'b0);
    e = exp_q.pop_front();
    apply_bit(1'b1, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if (ov_st !== 2'd0 || ov_out !== 1'b0 || ov_cnt !== 8'd0 || ov_st !== e.ov_st) begin
      n_errors++;
      $display("FAIL reset_priority: got st=%0d out=%0d cnt=%0d expected st=0 out=0 cnt=0",
               ov_st, ov_out, ov_cnt);
    end
    apply_bit(1'b0, 1'b0);
    e = exp_q.pop_front();
    if (ov_out === 1'b1) pulses++;
    apply_bit(1'b1, 1'b0);
    e = exp_q.pop_front();
    if (ov_out === 1'b1) pulses++;
    n_checks++;
    if (ov_st !== 2'd1 || ov_st !== e.ov_st || pulses != 0 || ov_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_restart: got st=%0d pulses=%0d cnt=%0d expected st=1 pulses=0 cnt=0",
               ov_st, pulses, ov_cnt);
    end
  endtask

  task automatic test_saturate();
    int   want[] = '{1, 2, 3, 3, 3};
    exp_t e;
    apply_bit(1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      apply_bit(1'b1, 1'b0);
      e = exp_q.pop_front();
      apply_bit(1'b0, 1'b0);
      e = exp_q.pop_front();
      apply_bit(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (c2_cnt !== e.c2_cnt || int'(c2_cnt) != want[k] || c2_out !== 1'b1) begin
        n_errors++;
        $display("FAIL saturate round %0d: got cnt=%0d out=%0d expected cnt=%0d out=1",
                 k, c2_cnt, c2_out, want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic prev_ov = 1'b0;
    apply_bit(1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 300; i++) begin
      apply_bit(1'($urandom_range(1, 0)), ($urandom_range(39, 0) == 0));
      e = exp_q.pop_front();
      n_checks++;
      if (ov_st !== e.ov_st || ov_out !== e.ov_out || ov_cnt !== e.ov_cnt ||
          no_st !== e.no_st || no_out !== e.no_out || no_cnt !== e.no_cnt ||
          c2_st !== e.c2_st || c2_out !== e.c2_out || c2_cnt !== e.c2_cnt) begin
        n_errors++;
        $display("FAIL random step %0d: got %0d/%0d/%0d %0d/%0d/%0d %0d/%0d/%0d expected %0d/%0d/%0d %0d/%0d/%0d %0d/%0d/%0d",
                 i, ov_st, ov_out, ov_cnt, no_st, no_out, no_cnt, c2_st, c2_out, c2_cnt,
                 e.ov_st, e.ov_out, e.ov_cnt, e.no_st, e.no_out, e.no_cnt,
                 e.c2_st, e.c2_out, e.c2_cnt);
      end
      if (prev_ov === 1'b1) begin
        n_checks++;
        if (ov_out !== 1'b0) begin
          n_errors++;
          $display("FAIL pulse_width step %0d: got out=%0d after a pulse expected 0", i, ov_out);
        end
      end
      prev_ov = ov_out;
    end
  endtask

  // Test sequence
  initial begin
    rst    = 1'b1;
    in_bit = 1'b0;
    m_ov   = '{hist: 3'b000, len: 0, cnt: 0};
    m_no   = '{hist: 3'b000, len: 0, cnt: 0};
    m_c2   = '{hist: 3'b000, len: 0, cnt: 0};
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overlap();
    test_no_match();
    test_reset_priority();
    test_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
